// File: rtl/ddr_upload_reader.sv
// ddr_upload_reader: serves 16-bit HPS upload reads from a one-line buffer
// that is filled from DDR with a single 64-bit burst on a miss.
module ddr_upload_reader #(
    parameter logic [31:0] DDR_BASE     = 32'h0000_0000,
    parameter int          BURST_LENGTH = 4,
    parameter int          ADDR_WIDTH   = 25
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  io_upload_cs,
    input  logic                  io_upload_rd,
    input  logic [ADDR_WIDTH-1:0] io_upload_addr,
    output logic                  io_upload_waitReq,
    output logic                  io_upload_valid,
    output logic [15:0]           io_upload_dout,
    output logic                  io_ddr_rd,
    output logic [31:0]           io_ddr_addr,
    output logic [7:0]            io_ddr_burstLength,
    input  logic                  io_ddr_waitReq,
    input  logic                  io_ddr_valid,
    input  logic [63:0]           io_ddr_dout
);

    localparam int LINE_BYTES = 8 * BURST_LENGTH;
    localparam int OFF_BITS   = $clog2(LINE_BYTES);
    localparam int BEAT_W     = (BURST_LENGTH > 1) ? $clog2(BURST_LENGTH) : 1;
    localparam int TAG_W      = ADDR_WIDTH - OFF_BITS;

    typedef enum logic [1:0] {IDLE, REQ, FILL, RESP} state_t;

    state_t             state_reg, state_next;

    logic [63:0]        line_mem [BURST_LENGTH];
    logic               line_valid_reg;
    logic [TAG_W-1:0]   line_tag_reg;
    logic [TAG_W-1:0]   fill_tag_reg;
    logic [BEAT_W-1:0]  fill_beat_reg;
    logic [1:0]         fill_lane_reg;
    logic [BEAT_W-1:0]  beat_cnt_reg;
    logic               fill_keep_reg;
    logic [31:0]        ddr_addr_reg;
    logic               cs_reg;
    logic [15:0]        dout_reg;

    // Address decode of the incoming request
    logic [TAG_W-1:0]   addr_tag;
    logic [BEAT_W-1:0]  addr_beat;
    logic [1:0]         addr_lane;
    logic [31:0]        addr_ext;
    logic [31:0]        line_base;
    logic               unused_addr_bit;

    assign addr_tag        = io_upload_addr[ADDR_WIDTH-1:OFF_BITS];
    assign addr_lane       = io_upload_addr[2:1];
    assign addr_ext        = 32'(io_upload_addr);
    assign line_base       = DDR_BASE + (addr_ext & ~32'(LINE_BYTES - 1));
    assign unused_addr_bit = io_upload_addr[0];

    generate
        if (BURST_LENGTH > 1) begin : g_beat_sel
            assign addr_beat = io_upload_addr[OFF_BITS-1:3];
        end else begin : g_beat_single
            assign addr_beat = '0;
        end
    endgenerate

    logic hit;
    logic rd_req;
    logic cs_fall;
    logic last_beat;

    assign hit       = line_valid_reg && (addr_tag == line_tag_reg);
    assign rd_req    = io_upload_rd && io_upload_cs;
    assign cs_fall   = cs_reg && !io_upload_cs;
    assign last_beat = (state_reg == FILL) && io_ddr_valid &&
                       (beat_cnt_reg == BEAT_W'(BURST_LENGTH - 1));

    // Halfword selection: a hit reads the addressed beat directly; the end of a
    // fill reads the latched beat, bypassing the buffer if it is arriving now.
    logic [BEAT_W-1:0]  rd_beat;
    logic [1:0]         rd_lane;
    logic [63:0]        src_word;
    logic [15:0]        src_lanes [4];
    logic [15:0]        sel_half;

    assign rd_beat  = (state_reg == IDLE) ? addr_beat : fill_beat_reg;
    assign rd_lane  = (state_reg == IDLE) ? addr_lane : fill_lane_reg;
    assign src_word = ((state_reg == FILL) && (beat_cnt_reg == fill_beat_reg))
                      ? io_ddr_dout : line_mem[rd_beat];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign src_lanes[gi] = src_word[16*gi +: 16];
        end
    endgenerate

    assign sel_half = src_lanes[rd_lane];

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (rd_req) begin
                    state_next = hit ? RESP : REQ;
                end
            end
            REQ: begin
                if (!io_ddr_waitReq) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                if (last_beat) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state
    always_comb begin
        io_ddr_rd         = 1'b0;
        io_upload_valid   = 1'b0;
        io_upload_waitReq = 1'b0;
        case (state_reg)
            IDLE: io_upload_waitReq = rd_req && !hit;
            REQ: begin
                io_ddr_rd         = 1'b1;
                io_upload_waitReq = 1'b1;
            end
            FILL: io_upload_waitReq = 1'b1;
            RESP: io_upload_valid   = 1'b1;
            default: ;
        endcase
    end

    assign io_ddr_addr        = ddr_addr_reg;
    assign io_ddr_burstLength = 8'(BURST_LENGTH);
    assign io_upload_dout     = dout_reg;

    // Line buffer storage, written one beat at a time during a fill
    always_ff @(posedge clock) begin
        if ((state_reg == FILL) && io_ddr_valid) begin
            line_mem[beat_cnt_reg] <= io_ddr_dout;
        end
    end

    // Request latching, beat counting, line tag/valid and read data
    always_ff @(posedge clock) begin
        if (reset) begin
            line_valid_reg <= 1'b0;
            line_tag_reg   <= '0;
            fill_tag_reg   <= '0;
            fill_beat_reg  <= '0;
            fill_lane_reg  <= '0;
            beat_cnt_reg   <= '0;
            fill_keep_reg  <= 1'b0;
            ddr_addr_reg   <= '0;
            cs_reg         <= 1'b0;
            dout_reg       <= '0;
        end else begin
            cs_reg <= io_upload_cs;
            case (state_reg)
                IDLE: begin
                    if (rd_req) begin
                        if (hit) begin
                            dout_reg <= sel_half;
                        end else begin
                            // The buffer is about to be overwritten
                            line_valid_reg <= 1'b0;
                            ddr_addr_reg   <= line_base;
                            fill_tag_reg   <= addr_tag;
                            fill_beat_reg  <= addr_beat;
                            fill_lane_reg  <= addr_lane;
                            fill_keep_reg  <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    beat_cnt_reg <= '0;
                end
                FILL: begin
                    if (io_ddr_valid) begin
                        beat_cnt_reg <= beat_cnt_reg + 1'b1;
                    end
                    if (last_beat) begin
                        dout_reg       <= sel_half;
                        line_tag_reg   <= fill_tag_reg;
                        line_valid_reg <= fill_keep_reg && !cs_fall;
                    end
                end
                default: ;
            endcase
            // End of session: forget the line, including one still being filled
            if (cs_fall) begin
                line_valid_reg <= 1'b0;
                fill_keep_reg  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ddr_upload_reader.sv
// Directed bench for ddr_upload_reader: a table of hit/miss reads plus
// hand-written session, mid-fill cs drop and mid-fill reset sequences.
module tb_ddr_upload_reader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        io_upload_cs = 1'b0;
    logic        io_upload_rd = 1'b0;
    logic [24:0] io_upload_addr = '0;
    logic        io_ddr_waitReq = 1'b0;
    logic        io_ddr_valid = 1'b0;
    logic [63:0] io_ddr_dout = '0;

    logic        io_upload_waitReq, io_upload_valid;
    logic [15:0] io_upload_dout;
    logic        io_ddr_rd;
    logic [31:0] io_ddr_addr;
    logic [7:0]  io_ddr_burstLength;

    logic        waitReq2, valid2, ddr_rd2;
    logic [15:0] dout2;
    logic [31:0] ddr_addr2;
    logic [7:0]  burst2;

    always #5 clock = ~clock;

    ddr_upload_reader u_dut (
        .clock(clock), .reset(reset),
        .io_upload_cs(io_upload_cs), .io_upload_rd(io_upload_rd),
        .io_upload_addr(io_upload_addr),
        .io_upload_waitReq(io_upload_waitReq), .io_upload_valid(io_upload_valid),
        .io_upload_dout(io_upload_dout),
        .io_ddr_rd(io_ddr_rd), .io_ddr_addr(io_ddr_addr),
        .io_ddr_burstLength(io_ddr_burstLength),
        .io_ddr_waitReq(io_ddr_waitReq), .io_ddr_valid(io_ddr_valid),
        .io_ddr_dout(io_ddr_dout)
    );

    // Second instance with a base that makes line addresses wrap past 2^32
    ddr_upload_reader #(.DDR_BASE(32'hFFFF_FFF0)) u_dut2 (
        .clock(clock), .reset(reset),
        .io_upload_cs(io_upload_cs), .io_upload_rd(io_upload_rd),
        .io_upload_addr(io_upload_addr),
        .io_upload_waitReq(waitReq2), .io_upload_valid(valid2),
        .io_upload_dout(dout2),
        .io_ddr_rd(ddr_rd2), .io_ddr_addr(ddr_addr2),
        .io_ddr_burstLength(burst2),
        .io_ddr_waitReq(io_ddr_waitReq), .io_ddr_valid(io_ddr_valid),
        .io_ddr_dout(io_ddr_dout)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int acc_cnt  = 0;
    int vld_cnt  = 0;

    // Count accepted DDR requests and upload responses
    always @(posedge clock) begin
        if (io_ddr_rd && !io_ddr_waitReq) acc_cnt <= acc_cnt + 1;
        if (io_upload_valid)             vld_cnt <= vld_cnt + 1;
    end

    typedef struct {
        logic [24:0] addr;
        bit          miss;
        logic [31:0] ddr;
        logic [31:0] ddr2;
        int          wt;
        logic [15:0] dout;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Beat i of the line at DDR address a: lane k = (0x1111*(i+1)) ^ (a[15:0]+k)
    function automatic logic [63:0] beat_data(input logic [31:0] a, input int i);
        logic [15:0] p;
        logic [15:0] b;
        p = 16'(16'h1111 * (i + 1));
        b = a[15:0];
        return {p ^ (b + 16'd3), p ^ (b + 16'd2), p ^ (b + 16'd1), p ^ b};
    endfunction

    task automatic issue(input logic [24:0] addr, input logic exp_wait);
        @(negedge clock);
        io_upload_cs   = 1'b1;
        io_upload_rd   = 1'b1;
        io_upload_addr = addr;
        #1;
        check("waitReq_at_rd", io_upload_waitReq, exp_wait);
        check("valid_before_rd", io_upload_valid, 1'b0);
        @(negedge clock);
        io_upload_rd = 1'b0;
    endtask

    task automatic serve(input logic [31:0] exp, input logic [31:0] exp2, input int wt);
        int a0;
        int bad;
        a0  = acc_cnt;
        bad = 0;
        #1;
        check("ddr_addr", io_ddr_addr, exp);
        check("ddr_addr_wrap", ddr_addr2, exp2);
        check("burstLength", {io_ddr_burstLength, burst2}, {8'd4, 8'd4});
        for (int w = 0; w < wt; w++) begin
            io_ddr_waitReq = 1'b1;
            #1;
            if (!io_ddr_rd || !ddr_rd2 || io_ddr_addr !== exp || ddr_addr2 !== exp2 || !io_upload_waitReq)
                bad++;
            @(negedge clock);
        end
        io_ddr_waitReq = 1'b0;
        #1;
        if (!io_ddr_rd || io_ddr_addr !== exp) bad++;
        check("req_held_stable", bad, 0);
        @(negedge clock);
        #1;
        check("ddr_rd_dropped", io_ddr_rd, 1'b0);
        check("one_accept", acc_cnt - a0, 1);
    endtask

    task automatic beats(input logic [31:0] line, input int n, input int drop);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            io_ddr_valid = 1'b1;
            io_ddr_dout  = beat_data(line, i);
            io_upload_cs = (i == drop) ? 1'b0 : 1'b1;
            #1;
            if (!io_upload_waitReq || io_upload_valid) bad++;
            @(negedge clock);
        end
        io_ddr_valid = 1'b0;
        io_upload_cs = 1'b1;
        check("waitReq_during_fill", bad, 0);
    endtask

    task automatic resp(input logic [15:0] exp);
        #1;
        check("valid_pulse", io_upload_valid, 1'b1);
        check("dout", io_upload_dout, exp);
        check("dout_wrap_inst", {15'd0, valid2, dout2}, {15'd0, 1'b1, exp});
        check("waitReq_in_resp", {io_upload_waitReq, waitReq2, io_ddr_rd}, 3'b000);
        @(negedge clock);
        #1;
        check("valid_one_cycle", io_upload_valid, 1'b0);
    endtask

    task automatic run_vec(input vec_t v);
        int a0;
        a0 = acc_cnt;
        if (v.miss) begin
            issue(v.addr, 1'b1);
            serve(v.ddr, v.ddr2, v.wt);
            beats(v.ddr, 4, -1);
            resp(v.dout);
        end else begin
            issue(v.addr, 1'b0);
            resp(v.dout);
            check("hit_no_ddr_req", acc_cnt - a0, 0);
        end
        $display("read addr=0x%07h miss=%0d dout=0x%04h", v.addr, v.miss, io_upload_dout);
    endtask

    initial begin
        vec_t v;
        int   a0;
        int   v0;

        vecs[0] = '{25'h0000010, 1'b1, 32'h0000_0000, 32'hFFFF_FFF0, 0, 16'h3333};
        vecs[1] = '{25'h0000016, 1'b0, 32'h0,         32'h0,         0, 16'h3330};
        vecs[2] = '{25'h0000002, 1'b0, 32'h0,         32'h0,         0, 16'h1110};
        vecs[3] = '{25'h000001E, 1'b0, 32'h0,         32'h0,         0, 16'h4447};
        vecs[4] = '{25'h0000020, 1'b1, 32'h0000_0020, 32'h0000_0010, 5, 16'h1131};
        vecs[5] = '{25'h000003A, 1'b0, 32'h0,         32'h0,         0, 16'h4465};
        vecs[6] = '{25'h0000010, 1'b1, 32'h0000_0000, 32'hFFFF_FFF0, 2, 16'h3333};
        vecs[7] = '{25'h1FFFFFE, 1'b1, 32'h01FF_FFE0, 32'h01FF_FFD0, 1, 16'hBBA7};
        vecs[8] = '{25'h1FFFFF9, 1'b0, 32'h0,         32'h0,         0, 16'hBBA4};

        // Reset state
        repeat (3) @(negedge clock);
        #1;
        check("reset_outputs", {io_ddr_rd, io_upload_waitReq, io_upload_valid}, 3'b000);
        check("reset_dout", io_upload_dout, 16'h0000);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Session end: cs toggles, previously cached line must be refetched
        @(negedge clock);
        io_upload_cs = 1'b0;
        @(negedge clock);
        io_upload_cs = 1'b1;
        v = '{25'h1FFFFF8, 1'b1, 32'h01FF_FFE0, 32'h01FF_FFD0, 0, 16'hBBA4};
        run_vec(v);

        // Read with cs low: no response, no DDR traffic
        @(negedge clock);
        io_upload_cs   = 1'b0;
        io_upload_rd   = 1'b1;
        io_upload_addr = 25'h1FFFFF8;
        a0 = acc_cnt;
        v0 = vld_cnt;
        #1;
        check("cs_low_waitReq", io_upload_waitReq, 1'b0);
        @(negedge clock);
        io_upload_rd = 1'b0;
        repeat (3) @(negedge clock);
        check("cs_low_no_resp", vld_cnt - v0, 0);
        check("cs_low_no_ddr", acc_cnt - a0, 0);
        $display("read addr=0x1fffff8 with cs low, responses=%0d", vld_cnt - v0);

        // cs drops mid-fill: fill completes but the line is not kept
        issue(25'h0000040, 1'b1);
        serve(32'h0000_0040, 32'h0000_0030, 0);
        beats(32'h0000_0040, 4, 1);
        resp(16'h1151);
        $display("read addr=0x0000040 with cs drop during fill");
        v = '{25'h0000040, 1'b1, 32'h0000_0040, 32'h0000_0030, 0, 16'h1151};
        run_vec(v);

        // Reset after two beats of a fill
        issue(25'h0000060, 1'b1);
        serve(32'h0000_0060, 32'h0000_0050, 0);
        beats(32'h0000_0060, 2, -1);
        reset = 1'b1;
        @(negedge clock);
        #1;
        check("midfill_reset_outputs", {io_ddr_rd, io_upload_waitReq, io_upload_valid}, 3'b000);
        check("midfill_reset_dout", io_upload_dout, 16'h0000);
        reset = 1'b0;
        $display("reset during fill of addr=0x0000060");
        run_vec(v);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
